// File: rtl/bsg_inv_shared_rr.sv
// bsg_inv_shared_rr
//   One width_p-bit bitwise inverter is shared among num_req_p requesters.
//   A round-robin arbiter grants at most one requester per cycle. Each
//   requester owns a private one-entry result slot, so a stalled consumer
//   only blocks its own requester.
//
// Ports
//   clk_i    : clock, rising edge
//   reset_i  : synchronous active-high reset
//   v_i      : [num_req_p]            requester r presents an operand
//   data_i   : [num_req_p*width_p]    operand r at [r*width_p +: width_p]
//   ready_o  : [num_req_p]            grant (operand consumed on v_i & ready_o)
//   v_o      : [num_req_p]            result slot r is valid
//   data_o   : [num_req_p*width_p]    result r = ~operand r
//   yumi_i   : [num_req_p]            consumer r takes its result (only when v_o[r])
//
// Also contains bsg_inv_shared_rr_chk, a protocol checker meant to be
// instantiated alongside the design in simulation.

module bsg_inv_shared_rr #(
  parameter int width_p   = 16,
  parameter int num_req_p = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           v_i,
  input  logic [num_req_p*width_p-1:0]   data_i,
  output logic [num_req_p-1:0]           ready_o,
  output logic [num_req_p-1:0]           v_o,
  output logic [num_req_p*width_p-1:0]   data_o,
  input  logic [num_req_p-1:0]           yumi_i
);

  // A single requester still needs a 1-bit pointer register.
  localparam int lg_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  logic [num_req_p-1:0]          slot_v_q,     slot_v_d;
  logic [num_req_p*width_p-1:0]  slot_data_q,  slot_data_d;
  logic [lg_w-1:0]               last_grant_q, last_grant_d;

  logic [num_req_p-1:0]          avail_s;
  logic [num_req_p-1:0]          elig_s;
  logic [num_req_p-1:0]          grant_s;
  logic [lg_w-1:0]               grant_idx_s;
  logic                          found_s;
  int                            idx_s;

  // Eligibility: a slot draining this cycle may be refilled in the same
  // cycle; nothing is eligible while reset is asserted.
  always_comb begin
    avail_s = ~slot_v_q | yumi_i;
    if (reset_i) begin
      elig_s = '0;
    end else begin
      elig_s = v_i & avail_s;
    end
  end

  // Round-robin search starting just after the last granted index;
  // ineligible requesters are skipped without consuming a turn.
  always_comb begin
    grant_s     = '0;
    found_s     = 1'b0;
    grant_idx_s = last_grant_q;
    idx_s       = 0;
    for (int i = 1; i <= num_req_p; i++) begin
      idx_s = (int'(last_grant_q) + i) % num_req_p;
      if (!found_s && elig_s[idx_s]) begin
        grant_s[idx_s] = 1'b1;
        found_s        = 1'b1;
        grant_idx_s    = lg_w'(idx_s);
      end else begin
        found_s        = found_s;
      end
    end
  end

  // Slot and pointer next state: a grant fills (or refills) a slot, a yumi
  // without a grant empties it; data is left stale when a slot empties.
  always_comb begin
    slot_v_d    = slot_v_q;
    slot_data_d = slot_data_q;
    for (int r = 0; r < num_req_p; r++) begin
      if (grant_s[r]) begin
        slot_v_d[r]                      = 1'b1;
        slot_data_d[r*width_p +: width_p] = ~data_i[r*width_p +: width_p];
      end else if (yumi_i[r]) begin
        slot_v_d[r]                      = 1'b0;
      end else begin
        slot_v_d[r]                      = slot_v_q[r];
      end
    end
    if (found_s) begin
      last_grant_d = grant_idx_s;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // State registers; reset puts requester 0 first in line.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slot_v_q     <= '0;
      slot_data_q  <= '0;
      last_grant_q <= lg_w'(num_req_p - 1);
    end else begin
      slot_v_q     <= slot_v_d;
      slot_data_q  <= slot_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign ready_o = grant_s;
  assign v_o     = slot_v_q;
  assign data_o  = slot_data_q;

endmodule

// bsg_inv_shared_rr_chk
//   Protocol checker for bsg_inv_shared_rr.
// Ports
//   clk_i, reset_i : same clock/reset as the design
//   grant_i        : the design's ready_o
//   slot_v_i       : the design's v_o
//   yumi_i         : the consumer's yumi_i
module bsg_inv_shared_rr_chk #(
  parameter int num_req_p = 2
) (
  input logic                 clk_i,
  input logic                 reset_i,
  input logic [num_req_p-1:0] grant_i,
  input logic [num_req_p-1:0] slot_v_i,
  input logic [num_req_p-1:0] yumi_i
);

  // A consumer may only take a result that is present.
  a_yumi_valid : assert property (@(posedge clk_i) disable iff (reset_i)
    ((yumi_i & ~slot_v_i) == '0));

  // The arbiter never grants more than one requester.
  a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(grant_i));

endmodule

// File: tb/tb_bsg_inv_shared_rr.sv
module tb_bsg_inv_shared_rr;

  localparam int W = 16;
  localparam int N = 2;

  logic              clk_i;
  logic              reset_i;
  logic [N-1:0]      v_i;
  logic [N*W-1:0]    data_i;
  logic [N-1:0]      ready_o;
  logic [N-1:0]      v_o;
  logic [N*W-1:0]    data_o;
  logic [N-1:0]      yumi_i;

  bsg_inv_shared_rr #(.width_p(W), .num_req_p(N)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .yumi_i  (yumi_i)
  );

  bsg_inv_shared_rr_chk #(.num_req_p(N)) chk (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .grant_i  (ready_o),
    .slot_v_i (v_o),
    .yumi_i   (yumi_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: one queue of expected results per requester, a
  // round-robin pointer, and the grant the rules predict for this cycle.
  logic [W-1:0]   exp_q [N][$];
  logic           exp_zero [N];
  int             ptr;
  logic [N-1:0]   exp_grant;
  logic           rst_applied;
  logic [N*W-1:0] cur_data;
  logic           mon_en;

  int checks;
  int errors;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: compare grant, slot valid and slot data against the model and
  // retire expected results on each output handshake.
  always @(negedge clk_i) begin
    if (mon_en) begin
      check("ready_o", W'(ready_o), W'(exp_grant));
      for (int r = 0; r < N; r++) begin
        check($sformatf("v_o[%0d]", r), W'(v_o[r]), W'(exp_q[r].size() > 0));
        if (exp_q[r].size() > 0) begin
          check($sformatf("data_o[%0d]", r), data_o[r*W +: W], exp_q[r][0]);
          if (yumi_i[r]) void'(exp_q[r].pop_front());
        end else if (exp_zero[r]) begin
          check($sformatf("data_o_rst[%0d]", r), data_o[r*W +: W], {W{1'b0}});
        end
      end
    end
  end

  // One cycle of stimulus: retire the previous edge into the model, then
  // drive new inputs and predict this cycle's grant.
  task automatic step(input logic rst, input logic [N-1:0] v,
                      input logic [N*W-1:0] d, input logic [N-1:0] ymask);
    logic [N-1:0] y;
    logic [W-1:0] op;
    int idx;
    @(posedge clk_i);
    #1;
    if (rst_applied) begin
      for (int r = 0; r < N; r++) begin
        exp_q[r].delete();
        exp_zero[r] = 1'b1;
      end
      ptr = N - 1;
    end else begin
      for (int r = 0; r < N; r++) begin
        if (exp_grant[r]) begin
          op = cur_data[r*W +: W];
          exp_q[r].push_back(~op);
          exp_zero[r] = 1'b0;
          ptr = r;
        end
      end
    end
    mon_en = 1'b1;
    y = '0;
    for (int r = 0; r < N; r++) y[r] = ymask[r] && (exp_q[r].size() > 0) && !rst;
    reset_i = rst;
    v_i     = v;
    data_i  = d;
    yumi_i  = y;
    exp_grant = '0;
    if (!rst) begin
      for (int k = 1; k <= N; k++) begin
        idx = (ptr + k) % N;
        if (exp_grant == '0 && v[idx] && (exp_q[idx].size() == 0 || y[idx]))
          exp_grant[idx] = 1'b1;
      end
    end
    rst_applied = rst;
    cur_data    = d;
  endtask

  initial begin
    logic [N*W-1:0] rd;
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    rst_applied = 1'b1;
    exp_grant = '0;
    cur_data = '0;
    ptr = N - 1;
    for (int r = 0; r < N; r++) exp_zero[r] = 1'b1;
    reset_i = 1'b1;
    v_i = '0;
    data_i = '0;
    yumi_i = '0;

    // Reset held two cycles with requests present, then first grant to 0.
    step(1'b1, 2'b11, {16'h2222, 16'h1111}, 2'b00);
    step(1'b1, 2'b11, {16'h2222, 16'h1111}, 2'b00);
    step(1'b0, 2'b11, {16'h2222, 16'h1111}, 2'b00);
    step(1'b0, 2'b00, {16'h0000, 16'h0000}, 2'b11);
    step(1'b0, 2'b00, {16'h0000, 16'h0000}, 2'b11);
    // Single request, result held until taken.
    step(1'b0, 2'b01, {16'h0000, 16'h00FF}, 2'b00);
    step(1'b0, 2'b00, {16'h0000, 16'h0000}, 2'b00);
    step(1'b0, 2'b00, {16'h0000, 16'h0000}, 2'b00);
    step(1'b0, 2'b00, {16'h0000, 16'h0000}, 2'b01);
    // Contention with consumers following v_o.
    for (int i = 0; i < 6; i++) step(1'b0, 2'b11, {16'hAAAA, 16'h1234}, 2'b11);
    step(1'b0, 2'b00, {16'h0000, 16'h0000}, 2'b11);
    // Backpressure on slot 0, then release.
    step(1'b0, 2'b01, {16'h0000, 16'h5A5A}, 2'b00);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b11, {16'hAAAA, 16'h1234}, 2'b10);
    step(1'b0, 2'b11, {16'hAAAA, 16'h1234}, 2'b11);
    // Same-cycle drain and refill of slot 0.
    step(1'b0, 2'b01, {16'h0000, 16'h0F0F}, 2'b01);
    step(1'b0, 2'b00, {16'h0000, 16'h0000}, 2'b00);
    // Fill both slots, reset mid-operation, requester 0 first afterwards.
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, {16'hBEEF, 16'hCAFE}, 2'b00);
    step(1'b1, 2'b11, {16'hBEEF, 16'hCAFE}, 2'b00);
    step(1'b0, 2'b11, {16'h3C3C, 16'h7E7E}, 2'b00);
    step(1'b0, 2'b11, {16'h3C3C, 16'h7E7E}, 2'b00);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      for (int r = 0; r < N; r++) rd[r*W +: W] = W'($urandom);
      step(($urandom_range(63) == 0), N'($urandom), rd, N'($urandom));
    end
    step(1'b0, '0, '0, '0);
    @(posedge clk_i);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
